seq_mult_ctrl: RTL and testbench

//  Iterative shift-add unsigned multiplier controller. Sequences one shared

---
 rtl/seq_mult_ctrl.sv | 110 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Iterative shift-add unsigned multiplier: one WIDTH-bit ripple adder reused for
// WIDTH cycles, with a start/busy/done handshake and a held product register.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:1]   carry;
    logic [WIDTH-1:0] next_acc;
    logic [WIDTH-1:0] next_mplier;
    logic             last_iter;

    // {carry, sum} for one bit position
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    assign addend = mplier[0] ? mcand : '0;

    always_comb begin
        sum_s = '0;
        carry = '0;
        {carry[1], sum_s[0]} = half_add(acc[0], addend[0]);
        for (int i = 1; i < WIDTH; i++) begin
            {carry[i+1], sum_s[i]} = full_add(acc[i], addend[i], carry[i]);
        end
    end

    // {cout, sum, mplier} shifted right by one, low 2*WIDTH bits kept
    assign next_acc    = {carry[WIDTH], sum_s[WIDTH-1:1]};
    assign next_mplier = {sum_s[0], mplier[WIDTH-1:1]};
    assign last_iter   = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= next_acc;
                    mplier <= next_mplier;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        // final partial product goes straight into the result register
                        product <= {next_acc, next_mplier};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: WIDTH=8 scenarios plus a WIDTH=4 exhaustive sweep.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start4;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic        busy8, done8, busy4, done4;
    logic [15:0] product8;
    logic [7:0]  product4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    seq_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    // Issue one op on the 8-bit unit and follow it until busy drops.
    // didx is the sample index (0 = right after the accepting edge) where done was seen.
    task automatic do_op8(input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int bcnt, output int dcnt,
                          output int didx, output bit tmo);
        a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        bcnt = 0; dcnt = 0; didx = -1; tmo = 1'b1; p = '0;
        for (int n = 0; n < 40; n++) begin
            if (done8) begin dcnt++; didx = n; p = product8; end
            if (busy8) bcnt++;
            else begin tmo = 1'b0; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy8, done8, product8} !== 18'd0) $display("FAIL reset8 got busy=%b done=%b product=%0d want 0/0/0", busy8, done8, product8);
        else pass_cnt++;
        total_cnt++;
        if ({busy4, done4, product4} !== 10'd0) $display("FAIL reset4 got busy=%b done=%b product=%0d want 0/0/0", busy4, done4, product4);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] p; int bc, dc, di; bit tmo;
        do_op8(8'd3, 8'd5, p, bc, dc, di, tmo);
        total_cnt++;
        if (tmo || p !== 16'd15) $display("FAIL basic_product got %0d (timeout=%0b) want 15", p, tmo);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 9) $display("FAIL basic_busy_cycles got %0d want 9", bc);
        else pass_cnt++;
        total_cnt++;
        if (dc !== 1) $display("FAIL basic_done_pulses got %0d want 1", dc);
        else pass_cnt++;
        total_cnt++;
        if (di !== 8) $display("FAIL basic_done_latency got %0d want 8", di);
        else pass_cnt++;
        // product must hold after the operation
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (product8 !== 16'd15 || done8 !== 1'b0) $display("FAIL basic_hold got product=%0d done=%b want 15/0", product8, done8);
        else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [15:0] p; int bc, dc, di; bit tmo;
        do_op8(8'd255, 8'd255, p, bc, dc, di, tmo);
        total_cnt++;
        if (tmo || dc !== 1 || p !== 16'hFE01) $display("FAIL max_product got %h dones=%0d want fe01/1", p, dc);
        else pass_cnt++;
        do_op8(8'd0, 8'd200, p, bc, dc, di, tmo);
        total_cnt++;
        if (tmo || dc !== 1 || p !== 16'd0) $display("FAIL zero_product got %0d dones=%0d want 0/1", p, dc);
        else pass_cnt++;
        do_op8(8'd200, 8'd1, p, bc, dc, di, tmo);
        total_cnt++;
        if (tmo || dc !== 1 || p !== 16'd200) $display("FAIL one_product got %0d dones=%0d want 200/1", p, dc);
        else pass_cnt++;
    endtask

    task automatic test_start_held();
        int dc = 0; bit seen = 1'b0; logic [15:0] p = '0;
        a8 = 8'd10; b8 = 8'd12; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd99; b8 = 8'd77;
        for (int n = 0; n < 9; n++) begin
            if (done8) begin dc++; p = product8; end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (dc !== 1 || p !== 16'd120) $display("FAIL held_product got %0d dones=%0d want 120/1", p, dc);
        else pass_cnt++;
        total_cnt++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL held_idle got busy=%b done=%b want 0/0", busy8, done8);
        else pass_cnt++;
        @(posedge clk); #1;
        start8 = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b1) $display("FAIL held_reaccept got busy=%b want 1", busy8);
        else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            if (done8) begin seen = 1'b1; p = product8; end
            if (!busy8) break;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (!seen || p !== 16'd7623) $display("FAIL held_second got %0d seen=%0b want 7623", p, seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int bc, dc, di; bit tmo;
        int spurious = 0;
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0)
            $display("FAIL midreset got busy=%b done=%b product=%0d want 0/0/0", busy8, done8, product8);
        else pass_cnt++;
        for (int n = 0; n < 12; n++) begin
            if (done8 || busy8) spurious++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (spurious !== 0) $display("FAIL midreset_quiet got %0d active cycles want 0", spurious);
        else pass_cnt++;
        do_op8(8'd7, 8'd9, p, bc, dc, di, tmo);
        total_cnt++;
        if (tmo || dc !== 1 || p !== 16'd63) $display("FAIL midreset_rerun got %0d dones=%0d want 63/1", p, dc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1;
        logic [15:0] p1 = '0, p2 = '0;
        a8 = 8'd6; b8 = 8'd7; start8 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (t1 < 0) begin
                    t1 = n; p1 = product8; a8 = 8'd13; b8 = 8'd11;
                end else begin
                    t2 = n; p2 = product8; start8 = 1'b0;
                    break;
                end
            end
        end
        start8 = 1'b0;
        total_cnt++;
        if (p1 !== 16'd42) $display("FAIL b2b_first got %0d want 42", p1);
        else pass_cnt++;
        total_cnt++;
        if (t2 < 0 || p2 !== 16'd143) $display("FAIL b2b_second got %0d (seen=%0b) want 143", p2, t2 >= 0);
        else pass_cnt++;
        total_cnt++;
        if (t2 - t1 !== 10) $display("FAIL b2b_spacing got %0d want 10", t2 - t1);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_sweep4();
        logic [7:0] p; bit got;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                @(posedge clk); #1;
                start4 = 1'b0;
                got = 1'b0; p = '0;
                for (int n = 0; n < 20; n++) begin
                    if (done4) begin got = 1'b1; p = product4; end
                    if (!busy4) break;
                    @(posedge clk); #1;
                end
                total_cnt++;
                if (!got || p !== 8'(x * y)) $display("FAIL sweep4 %0d*%0d got %0d seen=%0b want %0d", x, y, p, got, x * y);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        test_sweep4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
